// File: rtl/pdp_dp_pkg.sv
// Shared definitions for the PDP-11 datapath: address-select codes,
// ALU operand-select bit positions, bus FSM states and byte sign extension.
package pdp_dp_pkg;

   // Memory-address source selects (ctl_mem_addr)
   localparam logic [2:0] MA_SRC   = 3'd0;
   localparam logic [2:0] MA_SRC_X = 3'd1;
   localparam logic [2:0] MA_DST   = 3'd2;
   localparam logic [2:0] MA_DST_Y = 3'd3;
   localparam logic [2:0] MA_X     = 3'd4;
   localparam logic [2:0] MA_Y     = 3'd5;
   localparam logic [2:0] MA_Z     = 3'd6;

   // Bit positions inside ctl_alu_input
   localparam int unsigned AI_X = 32'd0;
   localparam int unsigned AI_Y = 32'd1;

   // Bus-side state machine
   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUS  = 1'b1
   } bus_state_t;

   // Sign-extend a byte to the widest supported datapath; callers size-cast
   function automatic logic [63:0] sext_byte(input logic [7:0] b);
      return {{56{b[7]}}, b};
   endfunction

endpackage

// File: rtl/pdp_regfile.sv
// General register file: NREGS x WIDTH, two asynchronous read ports,
// one synchronous write port, asynchronous active-low clear.
module pdp_regfile #(
   parameter int WIDTH  = 16,
   parameter int NREGS  = 8,
   parameter int RSEL_W = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [RSEL_W-1:0] rd_sel_a,
   input  logic [RSEL_W-1:0] rd_sel_b,
   input  logic [RSEL_W-1:0] wr_sel,
   input  logic              wr_en,
   input  logic [WIDTH-1:0]  wr_data,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic [WIDTH-1:0]  rd_data_b
);

   logic [WIDTH-1:0] regs [NREGS];

   // Register storage: cleared on reset, written on enabled edges
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en) begin
         regs[wr_sel] <= wr_data;
      end
   end

   // Reads see the stored value; a same-edge write shows up next cycle
   assign rd_data_a = regs[rd_sel_a];
   assign rd_data_b = regs[rd_sel_b];

endmodule

// File: rtl/datapath_bus.sv
// PDP-11 datapath: register file, X/Y/Z/IR/PSW latches, cycle counter and
// a req/ack memory bus interface with wait states, odd-address and timeout aborts.
module datapath_bus
   import pdp_dp_pkg::*;
#(
   parameter int WIDTH   = 16,
   parameter int NREGS   = 8,
   parameter int PSW_W   = 8,
   parameter int CYC_W   = 3,
   parameter int TIMEOUT = 15,
   parameter int RSEL_W  = $clog2(NREGS)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [RSEL_W-1:0] ctl_reg_src,
   input  logic [RSEL_W-1:0] ctl_reg_dst,
   input  logic [1:0]        ctl_alu_input,
   input  logic [2:0]        ctl_mem_addr,
   input  logic              ctl_mem_rd,
   input  logic              ctl_mem_we,
   input  logic              ctl_mem_byte,
   input  logic              ctl_reg_from_mem,
   input  logic              ctl_reg_we,
   input  logic              ctl_x_we,
   input  logic              ctl_y_we,
   input  logic              ctl_z_we,
   input  logic              ctl_psw_we,
   input  logic              ctl_ir_we,
   input  logic [CYC_W-1:0]  cycle_next,
   output logic [CYC_W-1:0]  cycle,
   output logic [WIDTH-1:0]  ir,
   output logic [PSW_W-1:0]  psw,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   input  logic [WIDTH-1:0]  alu_result,
   input  logic [PSW_W-1:0]  alu_psw,
   output logic              bus_req,
   output logic              bus_we,
   output logic              bus_byte,
   output logic [WIDTH-1:0]  bus_addr,
   output logic [WIDTH-1:0]  bus_wdata,
   input  logic [WIDTH-1:0]  bus_rdata,
   input  logic              bus_ack,
   output logic              stall,
   output logic              bus_error
);

   localparam int TCNT_W = $clog2(TIMEOUT + 1);

   bus_state_t        state;
   logic [TCNT_W-1:0] tcnt;
   logic [WIDTH-1:0]  x_lat, y_lat, z_lat;
   logic [WIDTH-1:0]  src_val, dst_val, mem_addr, rd_val, wdata_next, reg_wdata;
   logic [7:0]        rd_byte;
   logic              access, odd_abort, start, timeout_hit, commit;

   pdp_regfile #(.WIDTH(WIDTH), .NREGS(NREGS), .RSEL_W(RSEL_W)) u_regfile (
      .clk       (clk),
      .reset_n   (reset_n),
      .rd_sel_a  (ctl_reg_src),
      .rd_sel_b  (ctl_reg_dst),
      .wr_sel    (ctl_reg_dst),
      .wr_en     (commit & ctl_reg_we),
      .wr_data   (reg_wdata),
      .rd_data_a (src_val),
      .rd_data_b (dst_val)
   );

   assign alu_a = ctl_alu_input[AI_X] ? x_lat : src_val;
   assign alu_b = ctl_alu_input[AI_Y] ? y_lat : dst_val;

   // Effective address; sums wrap modulo 2^WIDTH
   always_comb begin
      mem_addr = z_lat;
      case (ctl_mem_addr)
         MA_SRC:   mem_addr = src_val;
         MA_SRC_X: mem_addr = src_val + x_lat;
         MA_DST:   mem_addr = dst_val;
         MA_DST_Y: mem_addr = dst_val + y_lat;
         MA_X:     mem_addr = x_lat;
         MA_Y:     mem_addr = y_lat;
         default:  mem_addr = z_lat;
      endcase
   end

   // Step classification: odd word addresses abort without ever requesting
   assign access      = ctl_mem_rd | ctl_mem_we;
   assign odd_abort   = (state == ST_IDLE) & access & ~ctl_mem_byte & mem_addr[0];
   assign start       = (state == ST_IDLE) & access & ~odd_abort;
   assign timeout_hit = (state == ST_BUS) & ~bus_ack & (tcnt == TCNT_W'(TIMEOUT - 1));
   assign commit      = ((state == ST_IDLE) & ~access) | ((state == ST_BUS) & bus_ack);
   assign stall       = start | ((state == ST_BUS) & ~bus_ack);

   // Read data: byte lane chosen by the latched address, sign-extended
   always_comb begin
      rd_byte = bus_addr[0] ? bus_rdata[15:8] : bus_rdata[7:0];
      if (bus_byte) begin
         rd_val = WIDTH'(sext_byte(rd_byte));
      end else begin
         rd_val = bus_rdata;
      end
   end

   // Write data: byte writes replicate the low byte onto both lanes
   always_comb begin
      wdata_next = alu_result;
      if (ctl_mem_byte) begin
         wdata_next        = '0;
         wdata_next[15:0]  = {alu_result[7:0], alu_result[7:0]};
      end else begin
         wdata_next = alu_result;
      end
   end

   assign reg_wdata = ctl_reg_from_mem ? rd_val : alu_result;

   // Bus FSM: request launch, wait-state counting, ack and timeout handling
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= ST_IDLE;
         tcnt      <= '0;
         bus_req   <= 1'b0;
         bus_we    <= 1'b0;
         bus_byte  <= 1'b0;
         bus_addr  <= '0;
         bus_wdata <= '0;
         bus_error <= 1'b0;
      end else begin
         bus_error <= odd_abort | timeout_hit;
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state     <= ST_BUS;
                  tcnt      <= '0;
                  bus_req   <= 1'b1;
                  bus_we    <= ctl_mem_we;
                  bus_byte  <= ctl_mem_byte;
                  bus_addr  <= mem_addr;
                  bus_wdata <= wdata_next;
               end else begin
                  state <= ST_IDLE;
               end
            end
            ST_BUS: begin
               if (bus_ack || timeout_hit) begin
                  state   <= ST_IDLE;
                  tcnt    <= '0;
                  bus_req <= 1'b0;
               end else begin
                  tcnt <= tcnt + TCNT_W'(1);
               end
            end
            default: begin
               state   <= ST_IDLE;
               tcnt    <= '0;
               bus_req <= 1'b0;
            end
         endcase
      end
   end

   // Architectural latches and cycle counter: commit on step completion, zero cycle on abort
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         x_lat <= '0;
         y_lat <= '0;
         z_lat <= '0;
         ir    <= '0;
         psw   <= '0;
         cycle <= '0;
      end else if (commit) begin
         if (ctl_x_we)   x_lat <= rd_val;
         if (ctl_y_we)   y_lat <= rd_val;
         if (ctl_z_we)   z_lat <= mem_addr;
         if (ctl_ir_we)  ir    <= rd_val;
         if (ctl_psw_we) psw   <= alu_psw;
         cycle <= cycle_next;
      end else if (odd_abort || timeout_hit) begin
         cycle <= '0;
      end
   end

endmodule
